// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//
// Round-robin scheduler that shares one external combinational
// single-precision adder among N requesters. A requester's operand pair is
// accepted with a valid/ready handshake and latched onto the adder inputs.
// One cycle later the adder's sum is captured and returned, tagged with the
// index of the requester that supplied the operands.
//
// Parameters
//   N    number of requesters (2..16)
//   IDW  requester ID width, 2**IDW >= N
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   [N]     per-requester operand valid
//   req_ready   [N]     per-requester accept (one-hot or zero, IDLE only)
//   req_a       [N*32]  operand A, requester i in bits [32i+31:32i]
//   req_b       [N*32]  operand B, same packing as req_a
//   add_a       [32]    operand A to the shared adder (registered)
//   add_b       [32]    operand B to the shared adder (registered)
//   add_sum     [32]    combinational sum returned by the shared adder
//   resp_valid          result available
//   resp_ready          consumer accepts result
//   resp_data   [32]    registered sum
//   resp_id     [IDW]   requester that owns resp_data
//   busy                high whenever the scheduler is not in IDLE
//
// Build option
//   FPADD_ARB_ZERO_BYPASS_EN  when defined, an operand whose exponent field is
//   zero (zero or denormal) is bypassed: the other operand is returned instead
//   of add_sum, working around the adder's forced hidden bit.
// ---------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*32-1:0]   req_a,
    input  logic [N*32-1:0]   req_b,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_sum,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // N expressed one bit wider than an ID so modulo-N wrap can be compared
    localparam logic [IDW:0] W_N = (IDW+1)'(N);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_gnt_id;
    logic [31:0]    r_add_a;
    logic [31:0]    r_add_b;
    logic           r_resp_valid;
    logic [31:0]    r_resp_data;
    logic [IDW-1:0] r_resp_id;

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_req_rot_full;
    logic [N-1:0]   w_req_rot;
    logic           w_gnt_any;
    logic [IDW-1:0] w_gnt_off;
    logic [IDW:0]   w_gnt_sum;
    logic [IDW-1:0] w_gnt_idx;
    logic [IDW:0]   w_nxt_ext;
    logic [IDW-1:0] w_nxt_ptr;
    logic           w_accept;
    logic [31:0]    w_sel_a;
    logic [31:0]    w_sel_b;
    logic [31:0]    w_result;

    // Rotate the request vector so that bit 0 corresponds to rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_req_dbl      = {req_valid, req_valid};
    assign w_req_rot_full = w_req_dbl >> r_rr_ptr;
    assign w_req_rot      = w_req_rot_full[N-1:0];

    // Lowest-offset requester wins: scan downward so the last hit is lowest.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_gnt_any = 1'b1;
                w_gnt_off = k[IDW-1:0];
            end
        end
    end

    // Map the offset back to an absolute requester index, modulo N. Both
    // terms are below N, so a single conditional subtract suffices.
    assign w_gnt_sum = {1'b0, r_rr_ptr} + {1'b0, w_gnt_off};
    assign w_gnt_idx = (w_gnt_sum >= W_N) ? IDW'(w_gnt_sum - W_N) : IDW'(w_gnt_sum);

    assign w_nxt_ext = {1'b0, w_gnt_idx} + (IDW+1)'(1);
    assign w_nxt_ptr = (w_nxt_ext == W_N) ? '0 : IDW'(w_nxt_ext);

    assign w_accept  = (r_state == S_IDLE) && w_gnt_any;
    assign req_ready = w_accept ? (N'(1) << w_gnt_idx) : '0;

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_a = req_a[i*32 +: 32];
                w_sel_b = req_b[i*32 +: 32];
            end
        end
    end

    // Value captured into resp_data at the end of ADD.
    always_comb begin
        w_result = add_sum;
`ifdef FPADD_ARB_ZERO_BYPASS_EN
        // Zero/denormal operands are mis-added by the adder's forced hidden
        // bit, so return the other operand unchanged instead.
        if (r_add_a[30:23] == 8'd0) begin
            w_result = r_add_b;
        end else if (r_add_b[30:23] == 8'd0) begin
            w_result = r_add_a;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_gnt_id     <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The pointer only moves on an accepted grant.
                    if (w_accept) begin
                        r_add_a  <= w_sel_a;
                        r_add_b  <= w_sel_b;
                        r_gnt_id <= w_gnt_idx;
                        r_rr_ptr <= w_nxt_ptr;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_resp_data  <= w_result;
                    r_resp_id    <= r_gnt_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // add_a/add_b are left untouched so the adder inputs
                    // stay quiet until the next grant.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_sum;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    logic [31:0] opa [N];
    logic [31:0] opb [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mptr  = 0;      // reference round-robin pointer
    int acc_cyc = 0;    // cycle of the most recent accept

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_a[gi*32 +: 32] = opa[gi];
        assign req_b[gi*32 +: 32] = opb[gi];
    end

    // Stand-in for the external adder: exact for the directed pairs used
    // below, a deterministic bit mix otherwise. The arbiter only forwards it.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4040_0000;
        return (a ^ {b[7:0], b[31:8]}) + 32'h0000_1357;
    endfunction

    assign add_sum = fake_add(add_a, add_b);

    // Expected response value for an operand pair.
    function automatic logic [31:0] exp_resp(input logic [31:0] a, input logic [31:0] b);
`ifdef FPADD_ARB_ZERO_BYPASS_EN
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
`endif
        return fake_add(a, b);
    endfunction

    // Reference grant: first valid requester at or after the pointer, wrapping.
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (req_valid[i] == 1'b1) return i;
        end
        return -1;
    endfunction

    fp_add_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction driven from IDLE. mode: 0 drop the served
    // request, 1 keep it asserted, 2 re-randomize it.
    task automatic do_txn(input int stall, input int mode);
        int g;
        logic [31:0] ea, eb, er;
        g = model_grant();
        if (g < 0) return;
        ea = opa[g];
        eb = opb[g];
        er = exp_resp(ea, eb);
        resp_ready = (stall == 0);
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(1 << g));
        tick();
        acc_cyc = cyc;
        mptr = (g + 1) % N;
        case (mode)
            0: req_valid[g[IDW-1:0]] = 1'b0;
            2: begin
                req_valid[g[IDW-1:0]] = 1'($urandom_range(0, 1));
                opa[g] = $urandom;
                opb[g] = $urandom;
            end
            default: ;
        endcase
        #1;
        check("add_a_latched", add_a, ea);
        check("add_b_latched", add_b, eb);
        check("busy_add", 32'(busy), 32'd1);
        check("resp_valid_add", 32'(resp_valid), 32'd0);
        check("req_ready_add", 32'(req_ready), 32'd0);
        tick();
        check("resp_valid_resp", 32'(resp_valid), 32'd1);
        check("resp_data", resp_data, er);
        check("resp_id", 32'(resp_id), 32'(g));
        check("req_ready_resp", 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", resp_data, er);
            check("stall_id", 32'(resp_id), 32'(g));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check("resp_valid_done", 32'(resp_valid), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        check("add_a_kept", add_a, ea);
        check("add_b_kept", add_b, eb);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        mptr = 0;
        tick();
        check("idle_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2: 1.0 + 2.0
        opa[2] = 32'h3F80_0000;
        opb[2] = 32'h4000_0000;
        req_valid = 4'b0100;
        do_txn(0, 0);
        check("single_sum", resp_data, 32'h4040_0000);

        // Pointer wrap: pointer sits at 3, requesters 0 and 3 valid
        opa[0] = $urandom; opb[0] = $urandom;
        opa[3] = $urandom; opb[3] = $urandom;
        req_valid = 4'b1001;
        #1;
        check("wrap_first_is_3", 32'(req_ready), 32'h8);
        do_txn(0, 0);
        do_txn(0, 0);

        // Idle cycles leave the pointer alone
        repeat (3) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Zero operand
        opa[1] = 32'h0000_0000;
        opb[1] = 32'h40A0_0000;
        req_valid = 4'b0010;
        do_txn(0, 0);

        // Backpressure: 10 stall cycles with another requester waiting
        opa[0] = $urandom; opb[0] = $urandom;
        opa[2] = $urandom; opb[2] = $urandom;
        req_valid = 4'b0101;
        do_txn(10, 0);
        do_txn(0, 0);

        // Reset during ADD discards the in-flight request
        opa[1] = $urandom; opb[1] = $urandom;
        req_valid = 4'b0010;
        #1;
        check("midrst_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("midrst_in_add", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_add_a", add_a, 32'd0);
        tick();
        rst = 1'b0;
        mptr = 0;
        repeat (4) begin
            tick();
            check("midrst_no_resp", 32'(resp_valid), 32'd0);
            check("midrst_idle", 32'(busy), 32'd0);
        end

        // All four requesting continuously: 0,1,2,3,0 three cycles apart
        opa[0] = 32'h3FC0_0000; opb[0] = 32'h3FC0_0000;
        for (int i = 1; i < N; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int prev;
            prev = acc_cyc;
            do_txn(0, 1);
            check("rotate_id", 32'(resp_id), 32'(k % N));
            if (k > 0) check("accept_spacing", 32'(acc_cyc - prev), 32'd3);
        end
        check("rotate_sum0", resp_data, 32'h4040_0000);
        req_valid = '0;
        tick();

        // Randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            if (req_valid == '0) begin
                if ($urandom_range(0, 1) == 0) begin
                    tick();
                    check("rand_idle_ready", 32'(req_ready), 32'd0);
                end
                for (int i = 0; i < N; i++) begin
                    opa[i] = $urandom;
                    opb[i] = $urandom;
                end
                req_valid = 4'($urandom_range(1, 15));
            end
            do_txn($urandom_range(0, 2), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
